// File: rtl/pattern_sequencer.sv
// Row-based note sequencer feeding the tracker voice: pattern memory plus tempo-paced playback.
// Build option: define PATTERN_SEQ_LOOP_EN to loop back to loop_row instead of stopping at last_row.
module pattern_sequencer #(
  parameter int unsigned ROWS     = 64,
  parameter int unsigned RLEN     = $clog2(ROWS),
  parameter int unsigned MAXSPEED = 16,
  parameter int unsigned SPLEN    = $clog2(MAXSPEED),
  parameter int unsigned TEMPO_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [RLEN-1:0]       wr_addr,
  input  logic [16+SPLEN-1:0]   wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic [TEMPO_W-1:0]    tempo,
  input  logic [RLEN-1:0]       last_row,
  input  logic [RLEN-1:0]       loop_row,
  output logic [15:0]           note,
  output logic [SPLEN-1:0]      speed,
  output logic [RLEN-1:0]       row,
  output logic                  row_strobe,
  output logic                  playing,
  output logic                  done
);

  localparam int unsigned   DW       = 16 + SPLEN;
  localparam logic [RLEN:0] ROWS_EXT = (RLEN+1)'(ROWS);
  localparam logic [RLEN-1:0] ROW_MAX = RLEN'(ROWS - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t state, state_nxt;

  logic [DW-1:0]      mem [ROWS];
  logic [TEMPO_W-1:0] tick, tempo_q;
  logic [RLEN-1:0]    last_q;

  logic [15:0]        note_nxt;
  logic [SPLEN-1:0]   speed_nxt;
  logic [RLEN-1:0]    row_nxt;
  logic               strobe_nxt, playing_nxt, done_nxt;
  logic [TEMPO_W-1:0] tick_nxt, tempo_nxt;
  logic [RLEN-1:0]    last_nxt;

  logic               row_end_c, at_last_c, present_c;
  logic [RLEN-1:0]    target_c, last_clamped_c;
  logic [DW-1:0]      rd_c;

  assign row_end_c      = (state == PLAY) && (tick == tempo_q);
  assign at_last_c      = (row >= last_q);
  assign last_clamped_c = ({1'b0, last_row} >= ROWS_EXT) ? ROW_MAX : last_row;

`ifndef PATTERN_SEQ_LOOP_EN
  logic unused_loop_row;
  assign unused_loop_row = ^loop_row;
`endif

  // Pattern memory; reads below are combinational so a same-row write returns old data.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < ROWS_EXT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = PLAY;
    end else if (row_end_c && at_last_c) begin
`ifdef PATTERN_SEQ_LOOP_EN
      state_nxt = PLAY;
`else
      state_nxt = IDLE;
`endif
    end
  end

  // Next values of the registered outputs and row timing.
  always_comb begin
    present_c   = 1'b0;
    target_c    = '0;
    rd_c        = '0;
    note_nxt    = note;
    speed_nxt   = speed;
    row_nxt     = row;
    strobe_nxt  = 1'b0;
    playing_nxt = playing;
    done_nxt    = 1'b0;
    tick_nxt    = tick;
    tempo_nxt   = tempo_q;
    last_nxt    = last_q;

    if (stop) begin
      note_nxt    = '0;
      speed_nxt   = '0;
      playing_nxt = 1'b0;
      tick_nxt    = '0;
    end else if (start) begin
      present_c = 1'b1;
    end else if (state == PLAY) begin
      if (!row_end_c) begin
        tick_nxt = tick + TEMPO_W'(1);
      end else if (!at_last_c) begin
        present_c = 1'b1;
        target_c  = row + RLEN'(1);
      end else begin
`ifdef PATTERN_SEQ_LOOP_EN
        present_c = 1'b1;
        target_c  = (loop_row > last_q) ? '0 : loop_row;
`else
        note_nxt    = '0;
        speed_nxt   = '0;
        playing_nxt = 1'b0;
        done_nxt    = 1'b1;
        tick_nxt    = '0;
`endif
      end
    end

    if (present_c) begin
      rd_c        = mem[target_c];
      note_nxt    = rd_c[15:0];
      speed_nxt   = rd_c[DW-1:16];
      row_nxt     = target_c;
      strobe_nxt  = 1'b1;
      playing_nxt = 1'b1;
      tick_nxt    = '0;
      tempo_nxt   = tempo;
      last_nxt    = last_clamped_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note       <= '0;
      speed      <= '0;
      row        <= '0;
      row_strobe <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
      tick       <= '0;
      tempo_q    <= '0;
      last_q     <= '0;
    end else begin
      note       <= note_nxt;
      speed      <= speed_nxt;
      row        <= row_nxt;
      row_strobe <= strobe_nxt;
      playing    <= playing_nxt;
      done       <= done_nxt;
      tick       <= tick_nxt;
      tempo_q    <= tempo_nxt;
      last_q     <= last_nxt;
    end
  end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Row-based note sequencer that sits directly upstream of the tracker voice and drives its `note` and `speed` inputs. It holds a small pattern memory of rows, each with a 16-bit note word and a phase-increment speed. A host writes the rows, then starts playback; the block steps through rows at a programmable tempo and presents each row's note/speed for exactly one row period.

## Interface
- `ROWS`, 64, pattern depth in rows
- `RLEN`, `$clog2(ROWS)`, row index width
- `MAXSPEED`, 16, matches tracker speed range
- `SPLEN`, `$clog2(MAXSPEED)`, speed field width
- `TEMPO_W`, 16, tempo counter width

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  pattern write strobe
- `wr_addr`  in  RLEN  row to write
- `wr_data`  in  16+SPLEN  row contents: `[15+SPLEN:16]` = speed, `[15:0]` = note word (opaque to this block)
- `start`  in  1  begin/restart playback at row 0
- `stop`  in  1  halt playback
- `tempo`  in  TEMPO_W  row period minus one, in clk cycles
- `last_row`  in  RLEN  final row of the pattern
- `loop_row`  in  RLEN  loop target (used only with `PATTERN_SEQ_LOOP_EN`)
- `note`  out  16  to tracker `note`
- `speed`  out  SPLEN  to tracker `speed`
- `row`  out  RLEN  index of row currently presented
- `row_strobe`  out  1  one-cycle pulse when a new row is presented
- `playing`  out  1  high in PLAY state
- `done`  out  1  one-cycle pulse on pattern end (non-loop build only)

## Operation
- States: IDLE, PLAY. Reset → IDLE. Reset values: `note`=0, `speed`=0, `row`=0, `row_strobe`=0, `playing`=0, `done`=0, tick counter=0. Reset does not clear the pattern memory.
- Memory: ROWS × (16+SPLEN), single write port, one read port. A write and a read of the same row in the same cycle return the old data (read-before-write).
- IDLE: outputs held at 0. `start`=1 → PLAY, present row 0.
- Row boundary: `note`/`speed` ← mem[row], `row_strobe`=1 for one cycle, `tempo` and `last_row` latched. Tick counter then counts 0..tempo_latched, giving a row length of tempo+1 cycles. `tempo`=0 gives a new row every cycle.
- End of row r:
  - r < latched `last_row` → row r+1.
  - r == `last_row` → end-of-pattern handling (see Configuration).
  - If `last_row` ≥ ROWS, it is clamped to ROWS-1.
- `stop` in any state → IDLE; next cycle `note`=0, `speed`=0, `playing`=0, `row` unchanged.
- Priority: `rst` > `stop` > `start` > normal stepping. `start` in PLAY restarts at row 0 immediately, discarding the current row's remaining ticks.
- Writes are accepted in every state. A write to a future row takes effect when that row is reached.

## Timing
- `start` sampled high at edge k:
  - Edge k+1: `playing`=1, `row`=0, `note`/`speed`=mem[0], `row_strobe`=1.
  - Row r is presented at edge k+1+r·(T+1), where T is the latched tempo.
- `note`/`speed` are registered outputs, stable for the whole row period. The tracker sees a new value on the same edge as `row_strobe`.
- `stop` latency: one cycle.
- `done` latency: one cycle after the last tick of `last_row`, i.e. the edge at which the next row would otherwise have been presented.

## Configuration
- `PATTERN_SEQ_LOOP_EN` defined, at the end of `last_row`:
  - Jump to `loop_row` (or to row 0 if `loop_row` > `last_row`) with a normal row boundary; playback continues indefinitely.
  - `done` is tied to 0.
- `PATTERN_SEQ_LOOP_EN` undefined, at the end of `last_row`:
  - → IDLE; `done`=1 for one cycle; `note`=0, `speed`=0, `playing`=0 on the same edge.
  - `loop_row` is ignored.

## Test plan
- Reset: assert `rst` 2 cycles mid-playback → all outputs 0, state IDLE; pattern contents still readable by replaying.
- Basic play: write rows 0..3 with note=16'h1000+i, speed=i+1; `tempo`=3, `last_row`=3, pulse `start` → note 1000,1001,1002,1003 presented at k+1, k+5, k+9, k+13; `row_strobe` only on those edges.
- End handling, non-loop build: `last_row`=3, `tempo`=3 → `done` pulse at k+17, `note`=0, `playing`=0. Loop build with `loop_row`=1 → rows 0,1,2,3,1,2,3,1… with no gap cycle.
- Tempo=0 and tempo change: `tempo`=0 → new row every cycle; changing `tempo` from 0 to 5 mid-row takes effect only from the next row boundary.
- Stop/start collisions: `stop` and `start` together in PLAY → IDLE next cycle. `start` alone at row 2 → row 0 presented the next cycle.
- Write during play: rewrite row 2 while row 1 is playing → new data presented at row 2. Rewrite the current row → `note` unchanged until the next visit.
